alu_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, the sequential companion to the combinational ALU in the CPU datapath. It executes signed and unsigned MULT/DIV over WIDTH-bit operands using an iterative shift-add multiplier and a restoring divider. A start/busy/done handshake lets the control unit stall the pipeline until the result is ready. MTHI/MTLO-style direct writes are also supported.

---
 rtl/alu_muldiv_if.sv | 28 ++
 rtl/alu_muldiv.sv | 193 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Handshake and data bundle between the control unit and the multiply/divide unit.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Operands are reduced to magnitudes, a shift-add multiplier or restoring
// divider runs one bit per cycle, and signs are restored in the FIX state.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rstn,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CW-1:0]      cnt_r;
    logic [1:0]         op_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic               dz_pend_r;
    logic [WIDTH-1:0]   mag_a_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               in_sign_a_s;
    logic               in_sign_b_s;
    logic               in_divzero_s;
    logic               accept_s;
    logic [WIDTH-1:0]   in_mag_a_s;
    logic [WIDTH-1:0]   in_mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Decode the incoming request: operand signs/magnitudes and acceptance.
    always_comb begin
        in_sign_a_s  = ~bus.op[0] & bus.a[WIDTH-1];
        in_sign_b_s  = ~bus.op[0] & bus.b[WIDTH-1];
        in_mag_a_s   = in_sign_a_s ? -bus.a : bus.a;
        in_mag_b_s   = in_sign_b_s ? -bus.b : bus.b;
        in_divzero_s = bus.op[1] & (bus.b == {WIDTH{1'b0}});
        accept_s     = (state_r == IDLE) & bus.start & ~bus.flush;
    end

    // One iteration: shift-add (multiply, LSB first) or restoring step (divide, MSB first).
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + ({(WIDTH+1){acc_r[0]}} & {1'b0, mag_b_r});
        div_trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_r};
        if (op_r[1]) begin
            if (!div_trial_s[WIDTH]) begin
                step_acc_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_acc_s = {acc_r[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the magnitude result; sign flags are zero for unsigned ops.
    always_comb begin
        prod_s   = (sign_a_r ^ sign_b_r) ? -acc_r : acc_r;
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
        if (dz_pend_r) begin
            // Rebuild the original dividend from its magnitude and sign.
            fix_hi_s = sign_a_r ? -mag_a_r : mag_a_r;
            fix_lo_s = {WIDTH{1'b1}};
        end else if (op_r[1]) begin
            fix_lo_s = (sign_a_r ^ sign_b_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
            fix_hi_s = sign_a_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = in_divzero_s ? FIX : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, result registers and handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r     <= {CW{1'b0}};
            op_r      <= 2'b00;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            dz_pend_r <= 1'b0;
            mag_a_r   <= {WIDTH{1'b0}};
            mag_b_r   <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_r      <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r      <= bus.op;
                        sign_a_r  <= in_sign_a_s;
                        sign_b_r  <= in_sign_b_s;
                        mag_a_r   <= in_mag_a_s;
                        mag_b_r   <= in_mag_b_s;
                        acc_r     <= {{WIDTH{1'b0}}, in_mag_a_s};
                        cnt_r     <= {CW{1'b0}};
                        dz_pend_r <= in_divzero_s;
                        dz_r      <= 1'b0;
                    end else if (!bus.start) begin
                        if (bus.hi_we) begin
                            hi_r <= bus.wdata;
                        end
                        if (bus.lo_we) begin
                            lo_r <= bus.wdata;
                        end
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        acc_r <= step_acc_s;
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi_r   <= fix_hi_s;
                        lo_r   <= fix_lo_s;
                        dz_r   <= dz_pend_r;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.dz   = dz_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: 32-bit instance plus an 8-bit instance.
module tb_alu_muldiv;
    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    int   n;
    logic saw_done;

    alu_muldiv_if #(.WIDTH(32)) bus32 ();
    alu_muldiv_if #(.WIDTH(8))  bus8 ();

    alu_muldiv #(.WIDTH(32)) u32 (.clk(clk), .rstn(rstn), .bus(bus32.slave));
    alu_muldiv #(.WIDTH(8))  u8  (.clk(clk), .rstn(rstn), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.a     = a;
        bus32.b     = b;
        tick();
        bus32.start = 1'b0;
    endtask

    // Count edges after the start edge until done is seen (bounded).
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus32.done && cnt < 60);
    endtask

    task automatic wait_done8(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus8.done && cnt < 30);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        bus32.start = 1'b0; bus32.op = 2'b00; bus32.a = 32'h0; bus32.b = 32'h0;
        bus32.flush = 1'b0; bus32.hi_we = 1'b0; bus32.lo_we = 1'b0; bus32.wdata = 32'h0;
        bus8.start = 1'b0; bus8.op = 2'b00; bus8.a = 8'h0; bus8.b = 8'h0;
        bus8.flush = 1'b0; bus8.hi_we = 1'b0; bus8.lo_we = 1'b0; bus8.wdata = 8'h0;
        tick();
        tick();
        check("rst_busy", {63'd0, bus32.busy}, 64'd0);
        check("rst_done", {63'd0, bus32.done}, 64'd0);
        check("rst_dz",   {63'd0, bus32.dz},   64'd0);
        check("rst_hi",   {32'd0, bus32.hi},   64'd0);
        check("rst_lo",   {32'd0, bus32.lo},   64'd0);
        rstn = 1'b1;
        tick();

        // MULT -3 * 5
        launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        check("mult_busy", {63'd0, bus32.busy}, 64'd1);
        wait_done(n);
        check("mult_lat", 64'(n), 64'd33);
        check("mult_hi", {32'd0, bus32.hi}, {32'd0, 32'hFFFF_FFFF});
        check("mult_lo", {32'd0, bus32.lo}, {32'd0, 32'hFFFF_FFF1});
        check("mult_busy_done", {63'd0, bus32.busy}, 64'd0);
        tick();
        check("mult_done_pulse", {63'd0, bus32.done}, 64'd0);

        // MULTU FFFFFFFF * FFFFFFFF
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        check("multu_hi", {32'd0, bus32.hi}, {32'd0, 32'hFFFF_FFFE});
        check("multu_lo", {32'd0, bus32.lo}, 64'd1);

        // DIV -7 / 2
        launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(n);
        check("div_lat", 64'(n), 64'd33);
        check("div_lo", {32'd0, bus32.lo}, {32'd0, 32'hFFFF_FFFD});
        check("div_hi", {32'd0, bus32.hi}, {32'd0, 32'hFFFF_FFFF});

        // DIVU 7 / 2
        launch(2'b11, 32'd7, 32'd2);
        wait_done(n);
        check("divu_lo", {32'd0, bus32.lo}, 64'd3);
        check("divu_hi", {32'd0, bus32.hi}, 64'd1);

        // DIV most-negative / -1
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        check("divovf_lo", {32'd0, bus32.lo}, {32'd0, 32'h8000_0000});
        check("divovf_hi", {32'd0, bus32.hi}, 64'd0);
        check("divovf_dz", {63'd0, bus32.dz}, 64'd0);

        // DIVU 7 / 0
        launch(2'b11, 32'd7, 32'd0);
        wait_done(n);
        check("dz_lat", 64'(n), 64'd1);
        check("dz_lo", {32'd0, bus32.lo}, {32'd0, 32'hFFFF_FFFF});
        check("dz_hi", {32'd0, bus32.hi}, 64'd7);
        check("dz_flag", {63'd0, bus32.dz}, 64'd1);

        // DIV -7 / 0 keeps the original negative dividend in HI
        launch(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_done(n);
        check("dzs_hi", {32'd0, bus32.hi}, {32'd0, 32'hFFFF_FFF9});
        check("dzs_lo", {32'd0, bus32.lo}, {32'd0, 32'hFFFF_FFFF});

        // Next accepted start clears dz
        launch(2'b11, 32'd9, 32'd3);
        check("dz_clear", {63'd0, bus32.dz}, 64'd0);
        wait_done(n);
        check("divu93_lo", {32'd0, bus32.lo}, 64'd3);
        check("divu93_hi", {32'd0, bus32.hi}, 64'd0);

        // MULT 6*7 with ignored start and ignored hi_we while busy
        launch(2'b00, 32'd6, 32'd7);
        n = 0;
        do begin
            if (n + 1 == 5) begin
                bus32.start = 1'b1; bus32.a = 32'd9; bus32.b = 32'd9;
            end
            if (n + 1 == 10) begin
                bus32.hi_we = 1'b1; bus32.wdata = 32'h1234_5678;
            end
            tick();
            n++;
            bus32.start = 1'b0;
            bus32.hi_we = 1'b0;
            if (n == 20) begin
                check("busy_hi_stable", {32'd0, bus32.hi}, 64'd0);
                check("busy_lo_stable", {32'd0, bus32.lo}, 64'd3);
            end
        end while (!bus32.done && n < 60);
        check("ign_lat", 64'(n), 64'd33);
        check("ign_hi", {32'd0, bus32.hi}, 64'd0);
        check("ign_lo", {32'd0, bus32.lo}, 64'h2A);
        tick();
        bus32.hi_we = 1'b1; bus32.wdata = 32'h1234_5678;
        tick();
        bus32.hi_we = 1'b0;
        check("mthi", {32'd0, bus32.hi}, {32'd0, 32'h1234_5678});
        check("mthi_lo_kept", {32'd0, bus32.lo}, 64'h2A);
        bus32.lo_we = 1'b1; bus32.wdata = 32'hCAFE_F00D;
        tick();
        bus32.lo_we = 1'b0;
        check("mtlo", {32'd0, bus32.lo}, {32'd0, 32'hCAFE_F00D});

        // Direct write ignored when start is asserted in the same cycle
        bus32.hi_we = 1'b1; bus32.wdata = 32'h0BAD_0BAD;
        launch(2'b01, 32'd2, 32'd3);
        bus32.hi_we = 1'b0;
        check("mthi_vs_start", {32'd0, bus32.hi}, {32'd0, 32'h1234_5678});
        wait_done(n);
        check("mult23_lo", {32'd0, bus32.lo}, 64'd6);
        bus32.hi_we = 1'b1; bus32.lo_we = 1'b1; bus32.wdata = 32'h1234_5678;
        tick();
        bus32.hi_we = 1'b0; bus32.lo_we = 1'b0;
        check("mt_both_hi", {32'd0, bus32.hi}, {32'd0, 32'h1234_5678});
        check("mt_both_lo", {32'd0, bus32.lo}, {32'd0, 32'h1234_5678});

        // DIV 100/3 flushed at cycle 10
        launch(2'b10, 32'd100, 32'd3);
        for (int i = 1; i < 10; i++) tick();
        bus32.flush = 1'b1;
        tick();
        bus32.flush = 1'b0;
        check("flush_busy", {63'd0, bus32.busy}, 64'd0);
        saw_done = bus32.done;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_done = saw_done | bus32.done;
        end
        check("flush_no_done", {63'd0, saw_done}, 64'd0);
        check("flush_hi", {32'd0, bus32.hi}, {32'd0, 32'h1234_5678});
        check("flush_lo", {32'd0, bus32.lo}, {32'd0, 32'h1234_5678});

        // flush together with start in IDLE: no launch
        bus32.flush = 1'b1;
        launch(2'b11, 32'd100, 32'd3);
        bus32.flush = 1'b0;
        check("flush_start_busy", {63'd0, bus32.busy}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_done = saw_done | bus32.done;
        end
        check("flush_start_no_done", {63'd0, saw_done}, 64'd0);

        // Asynchronous reset in the middle of a MULT
        launch(2'b00, 32'd6, 32'd7);
        for (int i = 1; i < 15; i++) tick();
        rstn = 1'b0;
        #1;
        check("arst_busy", {63'd0, bus32.busy}, 64'd0);
        check("arst_hi", {32'd0, bus32.hi}, 64'd0);
        check("arst_lo", {32'd0, bus32.lo}, 64'd0);
        rstn = 1'b1;
        tick();
        tick();
        check("arst_idle", {63'd0, bus32.busy}, 64'd0);

        // Back-to-back: start in the done cycle is accepted
        launch(2'b01, 32'd3, 32'd4);
        wait_done(n);
        check("b2b_first_lo", {32'd0, bus32.lo}, 64'd12);
        launch(2'b11, 32'd100, 32'd7);
        check("b2b_busy", {63'd0, bus32.busy}, 64'd1);
        check("b2b_done_low", {63'd0, bus32.done}, 64'd0);
        wait_done(n);
        check("b2b_lat", 64'(n), 64'd33);
        check("b2b_lo", {32'd0, bus32.lo}, 64'd14);
        check("b2b_hi", {32'd0, bus32.hi}, 64'd2);

        // WIDTH=8: -128 / -1
        bus8.start = 1'b1; bus8.op = 2'b10; bus8.a = 8'h80; bus8.b = 8'hFF;
        tick();
        bus8.start = 1'b0;
        wait_done8(n);
        check("w8_div_lat", 64'(n), 64'd9);
        check("w8_div_lo", {56'd0, bus8.lo}, 64'h80);
        check("w8_div_hi", {56'd0, bus8.hi}, 64'h00);

        // WIDTH=8: MULT -128 * -1 and MULTU FF * FF
        bus8.start = 1'b1; bus8.op = 2'b00; bus8.a = 8'h80; bus8.b = 8'hFF;
        tick();
        bus8.start = 1'b0;
        wait_done8(n);
        check("w8_mult_hi", {56'd0, bus8.hi}, 64'h00);
        check("w8_mult_lo", {56'd0, bus8.lo}, 64'h80);
        bus8.start = 1'b1; bus8.op = 2'b01; bus8.a = 8'hFF; bus8.b = 8'hFF;
        tick();
        bus8.start = 1'b0;
        wait_done8(n);
        check("w8_multu_hi", {56'd0, bus8.hi}, 64'hFE);
        check("w8_multu_lo", {56'd0, bus8.lo}, 64'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
